// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline. It keeps a scoreboard of register
// writes still in flight, stalls on RAW hazards and flushes after taken branches.
module hazard_cell #(
  parameter int LAT = 3,
  parameter int PW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  output logic [PW-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= PW'(LAT);
    else if (cnt != '0)  cnt <= cnt - PW'(1);
  end
endmodule

module hazard_ctrl #(
  parameter int LAT      = 3,
  parameter int BR_FLUSH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_wreg,
  input  logic [4:0]  id_destR,
  input  logic        br_taken,
  output logic        pc_stall,
  output logic        if_id_hold,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  localparam int PW = $clog2(LAT + 1);
  localparam int FW = (BR_FLUSH > 1) ? $clog2(BR_FLUSH) : 1;

  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} st_t;

  st_t           st, st_n;
  logic [FW-1:0] fc, fc_n;
  logic [PW-1:0] pend [32];
  logic          rs_busy, rt_busy, hazard, flush_now, issue;

  assign pend[0] = '0;

  // $0 is hard-wired, so only entries 1..31 ever hold a countdown
  for (genvar gi = 1; gi < 32; gi++) begin : g_sb
    hazard_cell #(.LAT(LAT), .PW(PW)) u_cell (
      .clk  (clk),
      .rst  (rst),
      .load (issue && id_wreg && (id_destR == 5'(gi))),
      .cnt  (pend[gi])
    );
  end

  assign rs_busy   = id_use_rs && (id_rs != 5'd0) && (pend[id_rs] != '0);
  assign rt_busy   = id_use_rt && (id_rt != 5'd0) && (pend[id_rt] != '0);
  // reset masks every combinational output so nothing leaks while rst is high
  assign hazard    = !rst && id_valid && (rs_busy || rt_busy);
  assign flush_now = !rst && (br_taken || st == FLUSH);
  assign issue     = !rst && id_valid && !hazard && !flush_now;

  assign pc_stall     = hazard && !flush_now;
  assign if_id_hold   = pc_stall;
  assign if_id_flush  = flush_now;
  assign id_ex_bubble = hazard || flush_now;
  assign state        = st;

  always_comb begin
    st_n = st;
    fc_n = fc;
    case (st)
      RUN, STALL: begin
        if (br_taken) begin
          st_n = FLUSH;
          fc_n = FW'(BR_FLUSH - 1);
        end else begin
          st_n = hazard ? STALL : RUN;
        end
      end
      FLUSH: begin
        if (br_taken)        fc_n = FW'(BR_FLUSH - 1);
        else if (fc == '0)   st_n = hazard ? STALL : RUN;
        else                 fc_n = fc - FW'(1);
      end
      default: st_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= RUN;
      fc        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      st <= st_n;
      fc <= fc_n;
      if (pc_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (br_taken && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
endmodule
